// File: rtl/gstmcu_video_pkg.sv
// Shared video types for the GSTMCU: fetch FSM states, resolution codes,
// bitplane count per resolution and the default LOAD strobe length.
package gstmcu_video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PULSE = 2'd2
  } fetch_state_t;

  localparam logic [1:0] REZ_LOW  = 2'd0;
  localparam logic [1:0] REZ_MID  = 2'd1;
  localparam logic [1:0] REZ_HIGH = 2'd2;

  localparam int LOAD_LEN_DEF = 4;

  // One word per bitplane is needed to fill the shifter for a hard scroll.
  function automatic logic [2:0] planes(input logic [1:0] rez);
    case (rez)
      REZ_LOW: planes = 3'd4;
      REZ_MID: planes = 3'd2;
      default: planes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/shifter_fetch_addr.sv
// Video address counter: vbase reload on vsync, +1 per fetched word and a
// single end-of-line offset add per line. vsync outranks everything else.
module shifter_fetch_addr #(
  parameter int ADDR_W = 23
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              vsync_rise,
  input  logic              de_rise,
  input  logic              inc,
  input  logic              eol_ready,
  input  logic [ADDR_W-1:0] vbase,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] vaddr
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Starts closed so nothing is added before the first visible line.
  logic line_closed;

  always_ff @(posedge clk32) begin
    if (reset) begin
      vaddr       <= '0;
      line_closed <= 1'b1;
    end else if (vsync_rise) begin
      vaddr       <= vbase;
      line_closed <= 1'b1;
    end else begin
      if (inc) begin
        vaddr <= vaddr + ONE;
      end else if (eol_ready && !line_closed) begin
        vaddr       <= vaddr + offset;
        line_closed <= 1'b1;
      end
      if (de_rise) line_closed <= 1'b0;
    end
  end

endmodule

// File: rtl/shifter_fetch.sv
// Video word fetcher for shifter_video: one RAM read per video slot, LOAD
// strobe per word. STE hard scroll and line offset exist only with STE_SCROLL_EN.
module shifter_fetch
  import gstmcu_video_pkg::*;
#(
  parameter int LOAD_LEN = LOAD_LEN_DEF,
  parameter int ADDR_W   = 23
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              slot_en,
  input  logic              DE,
  input  logic              vsync,
  input  logic [1:0]        rez,
  input  logic [ADDR_W-1:0] vbase,
  input  logic [7:0]        line_offset,
  input  logic [3:0]        hscroll,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [15:0]       ram_din,
  output logic              LOAD,
  output logic [15:0]       DOUT,
  output logic              scroll,
  output logic [ADDR_W-1:0] vaddr,
  output logic              overrun
);

  localparam int             CW         = $clog2(LOAD_LEN);
  localparam logic [CW-1:0]  PULSE_LAST = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  fetch_state_t      state, state_next;
  logic [CW-1:0]     pulse_cnt;
  logic              de_q, vsync_q, skip_inc, is_extra;
  logic [2:0]        extra;
  logic [ADDR_W-1:0] offset_ext;
  logic              vsync_rise, de_rise, fetch_active, ack, eol_ready;

  assign vsync_rise   = vsync & ~vsync_q;
  assign de_rise      = DE & ~de_q;
  assign fetch_active = DE | (extra != 3'd0);
  assign ack          = (state == REQ) & ram_ack;
  // Wait one cycle after DE falls so a freshly loaded extra count is seen first.
  assign eol_ready    = ~DE & ~de_q & (extra == 3'd0) & (state == IDLE);

  assign ram_req  = (state == REQ);
  assign ram_addr = vaddr;
  assign LOAD     = (state == PULSE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (slot_en && fetch_active) state_next = REQ;
      REQ:     if (ram_ack) state_next = PULSE;
      PULSE:   if (pulse_cnt == PULSE_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      DOUT      <= '0;
      overrun   <= 1'b0;
      de_q      <= 1'b0;
      vsync_q   <= 1'b0;
      skip_inc  <= 1'b0;
      is_extra  <= 1'b0;
    end else begin
      state   <= state_next;
      de_q    <= DE;
      vsync_q <= vsync;
      if (state == IDLE && state_next == REQ) is_extra <= ~DE;
      pulse_cnt <= (state == PULSE) ? pulse_cnt + CNT_ONE : '0;
      // A vsync during a pending read lets the data through but keeps vaddr at vbase.
      if (ack) begin
        DOUT     <= ram_din;
        skip_inc <= 1'b0;
      end else if (vsync_rise && state == REQ) begin
        skip_inc <= 1'b1;
      end
      if (slot_en && state != IDLE) overrun <= 1'b1;
    end
  end

`ifdef STE_SCROLL_EN
  logic de_fall;
  assign de_fall    = ~DE & de_q;
  assign scroll     = (hscroll != 4'd0);
  assign offset_ext = {{(ADDR_W-8){1'b0}}, line_offset};

  always_ff @(posedge clk32) begin
    if (reset || vsync_rise) begin
      extra <= 3'd0;
    end else if (de_fall && hscroll != 4'd0) begin
      extra <= planes(rez);
    end else if (ack && is_extra && extra != 3'd0) begin
      extra <= extra - 3'd1;
    end
  end
`else
  logic unused_ste;
  assign unused_ste = ^{rez, hscroll, line_offset, is_extra};
  assign scroll     = 1'b0;
  assign offset_ext = '0;
  assign extra      = 3'd0;
`endif

  shifter_fetch_addr #(.ADDR_W(ADDR_W)) u_addr (
    .clk32      (clk32),
    .reset      (reset),
    .vsync_rise (vsync_rise),
    .de_rise    (de_rise),
    .inc        (ack & ~skip_inc),
    .eol_ready  (eol_ready),
    .vbase      (vbase),
    .offset     (offset_ext),
    .vaddr      (vaddr)
  );

endmodule

// File: tb/tb_shifter_fetch.sv
// Bench for shifter_fetch: free-running video slots, a RAM responder with
// random latency and data, and a line-level address model.
module tb_shifter_fetch;

  localparam int LOAD_LEN = 4;
`ifdef STE_SCROLL_EN
  localparam bit STE = 1'b1;
`else
  localparam bit STE = 1'b0;
`endif

  logic        clk32 = 1'b0;
  logic        reset, slot_en, DE, vsync;
  logic [1:0]  rez;
  logic [22:0] vbase;
  logic [7:0]  line_offset;
  logic [3:0]  hscroll;
  logic        ram_req, ram_ack, LOAD, scroll, overrun;
  logic [22:0] ram_addr, vaddr;
  logic [15:0] ram_din, DOUT;

  shifter_fetch #(.LOAD_LEN(LOAD_LEN), .ADDR_W(23)) dut (
    .clk32(clk32), .reset(reset), .slot_en(slot_en), .DE(DE), .vsync(vsync),
    .rez(rez), .vbase(vbase), .line_offset(line_offset), .hscroll(hscroll),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_din(ram_din),
    .LOAD(LOAD), .DOUT(DOUT), .scroll(scroll), .vaddr(vaddr), .overrun(overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk32 = ~clk32;

  int n_checks = 0, n_bad = 0;
  int cyc = 0, slot_count = 0, ack_count = 0, ack_cyc = 0;
  logic slot_at_edge = 1'b0;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [22:0] m_addr = '0;
  bit          m_skip = 1'b0;
  int          lat_force = 3;
  bit          stray_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int planes_of(input logic [1:0] r);
    return (r == 2'd0) ? 4 : (r == 2'd1) ? 2 : 1;
  endfunction

  function automatic int exp_extra();
    return (STE && hscroll != 4'd0) ? planes_of(rez) : 0;
  endfunction

  function automatic logic [22:0] exp_add();
    return STE ? {15'd0, line_offset} : 23'd0;
  endfunction

  always @(posedge clk32) begin
    cyc          <= cyc + 1;
    slot_at_edge <= slot_en;
    if (slot_en) slot_count <= slot_count + 1;
  end

  // Video slot every 16 cycles, independent of reset.
  initial begin
    int phase;
    phase = 0;
    slot_en = 1'b0;
    forever begin
      @(negedge clk32);
      slot_en = (phase == 0);
      phase = (phase + 1) % 16;
    end
  end

  // RAM responder: acks each request after a latency, checks the address.
  initial begin
    int wait_cnt, cur_lat;
    wait_cnt = 0; cur_lat = 0;
    ram_ack = 1'b0; ram_din = '0;
    forever begin
      @(negedge clk32);
      ram_ack = 1'b0;
      if (stray_ack) begin
        ram_ack = 1'b1;
        ram_din = 16'hdead;
        stray_ack = 1'b0;
      end else if (ram_req) begin
        if (wait_cnt == 0) cur_lat = (lat_force >= 0) ? lat_force : $urandom_range(0, 6);
        if (wait_cnt >= cur_lat) begin
          ram_ack = 1'b1;
          ram_din = 16'($urandom);
          check("ram_addr", ram_addr, m_addr);
          if (m_skip) m_skip = 1'b0;
          else m_addr = m_addr + 23'd1;
          exp_q.push_back(ram_din);
          ack_count++;
          ack_cyc = cyc;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Output monitor: LOAD latency/width, DOUT contents, request latency.
  initial begin
    logic load_prev, req_prev;
    int load_w;
    load_prev = 1'b0; req_prev = 1'b0; load_w = 0;
    forever begin
      @(negedge clk32);
      if (reset) begin
        load_prev = 1'b0; req_prev = 1'b0; load_w = 0;
      end else begin
        if (LOAD && !load_prev) begin
          check("load_lat", cyc - ack_cyc, 1);
          if (exp_q.size() == 0) check("dout_unexpected", 32'(LOAD), 0);
          else check("dout", DOUT, exp_q.pop_front());
        end
        if (LOAD) load_w++;
        else if (load_prev) begin
          check("load_len", load_w, LOAD_LEN);
          load_w = 0;
        end
        if (ram_req && !req_prev) check("req_lat", 32'(slot_at_edge), 1);
        load_prev = LOAD;
        req_prev  = ram_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk32);
    reset = 1'b1;
    repeat (3) @(negedge clk32);
    exp_q.delete();
    m_addr = '0;
    m_skip = 1'b0;
    reset = 1'b0;
    @(negedge clk32);
  endtask

  task automatic pulse_vsync(input logic [22:0] base);
    @(negedge clk32);
    vbase = base;
    vsync = 1'b1;
    m_addr = base;
    repeat (2) @(negedge clk32);
    vsync = 1'b0;
    repeat (2) @(negedge clk32);
  endtask

  task automatic run_line(input int n, input int exp_acks, input logic [22:0] add);
    int s, a, guard;
    @(negedge clk32);
    s = slot_count; a = ack_count; guard = 0;
    DE = 1'b1;
    while (slot_count < s + n && guard < n * 16 + 32) begin
      @(negedge clk32);
      guard++;
    end
    check("line_slots", slot_count - s, n);
    DE = 1'b0;
    repeat (7 * 16) @(negedge clk32);
    m_addr = m_addr + add;
    check("line_acks", ack_count - a, exp_acks);
    check("line_vaddr", vaddr, m_addr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, guard, a;
    logic [22:0] nb;
    reset = 1'b1; DE = 1'b0; vsync = 1'b0; rez = 2'd0;
    vbase = '0; line_offset = 8'd0; hscroll = 4'd0;
    do_reset();
    check("rst_req", ram_req, 0);
    check("rst_load", LOAD, 0);
    check("rst_dout", DOUT, 0);
    check("rst_vaddr", vaddr, 0);
    check("rst_overrun", overrun, 0);

    // Basic fetch and line offset: two 40-word lines, one add each.
    line_offset = 8'd8;
    pulse_vsync(23'h1000);
    check("vsync_load", vaddr, 23'h1000);
    run_line(40, 40, exp_add());
    check("line2_start", vaddr, STE ? 23'h1030 : 23'h1028);
    run_line(40, 40, exp_add());

    // Hard scroll: low rez gives 4 extra words, high rez 1.
    hscroll = 4'd5; rez = 2'd0;
    @(negedge clk32);
    check("scroll", scroll, STE ? 1 : 0);
    run_line(10, 10 + exp_extra(), exp_add());
    rez = 2'd2;
    run_line(5, 5 + exp_extra(), exp_add());

    // Randomized lines with random latency, resolution and scroll.
    lat_force = -1;
    for (int i = 0; i < 8; i++) begin
      rez = 2'($urandom_range(0, 3));
      hscroll = 4'($urandom_range(0, 15));
      line_offset = 8'($urandom);
      if (i == 4) pulse_vsync(23'($urandom));
      n = $urandom_range(1, 12);
      @(negedge clk32);
      check("scroll_rand", scroll, (STE && hscroll != 0) ? 1 : 0);
      run_line(n, n + exp_extra(), exp_add());
    end

    // Address wrap at the top of the word space.
    hscroll = 4'd0; line_offset = 8'd20;
    pulse_vsync(23'h7ffffd);
    run_line(6, 6, exp_add());

    // vsync while a read is pending: data delivered, vaddr stays at vbase.
    lat_force = 8;
    nb = 23'h2a000;
    @(negedge clk32);
    a = ack_count; DE = 1'b1; guard = 0;
    while (!ram_req && guard < 40) begin
      @(negedge clk32);
      guard++;
    end
    check("vs_req_seen", ram_req, 1);
    DE = 1'b0; vbase = nb; vsync = 1'b1; m_addr = nb; m_skip = 1'b1;
    repeat (3) @(negedge clk32);
    vsync = 1'b0;
    repeat (40) @(negedge clk32);
    check("vs_acks", ack_count - a, 1);
    check("vs_vaddr", vaddr, nb);
    lat_force = 3;
    run_line(3, 3, exp_add());

    // Overrun: a long ack makes the next slot drop; sticky afterwards.
    check("ovr_before", overrun, 0);
    lat_force = 20;
    run_line(2, 1, exp_add());
    check("ovr_set", overrun, 1);
    lat_force = 3;
    run_line(2, 2, exp_add());
    check("ovr_sticky", overrun, 1);

    // Reset in REQ, then a stray ack after reset must be ignored.
    lat_force = 10;
    @(negedge clk32);
    DE = 1'b1; guard = 0;
    while (!ram_req && guard < 40) begin
      @(negedge clk32);
      guard++;
    end
    check("rst_req_seen", ram_req, 1);
    reset = 1'b1;
    @(negedge clk32);
    check("rstmid_req", ram_req, 0);
    check("rstmid_load", LOAD, 0);
    check("rstmid_vaddr", vaddr, 0);
    check("rstmid_overrun", overrun, 0);
    exp_q.delete();
    m_addr = '0; m_skip = 1'b0;
    reset = 1'b0; DE = 1'b0; stray_ack = 1'b1;
    repeat (4) @(negedge clk32);
    check("stray_load", LOAD, 0);
    check("stray_dout", DOUT, 0);
    check("stray_vaddr", vaddr, 0);

    repeat (20) @(negedge clk32);
    check("dout_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/shifter_fetch.md
Name: shifter_fetch

Overview:
- Video word fetcher that feeds shifter_video. Walks the video address counter, reads screen words from RAM in fixed video slots, and presents each word on DOUT with a LOAD strobe for the shifter's DIN/LOAD inputs.
- Reloads the counter from the screen base at vsync, adds the STe line offset at end of line, and fetches the extra hard-scroll words.
- Sits between the bus arbiter/RAM controller and shifter_video inside the GSTMCU.

Parameters:
- LOAD_LEN, 4, clk32 cycles LOAD stays high per word (minimum 2).
- ADDR_W, 23, word-address width (byte address bits 23:1).

Ports:
- clk32  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- slot_en  in  1  one-cycle pulse every 16 clk32 marking a video bus slot.
- DE  in  1  display enable from the timing generator.
- vsync  in  1  vertical sync; rising edge reloads the address.
- rez  in  2  resolution: 0 low (4 planes), 1 mid (2), 2/3 high (1).
- vbase  in  ADDR_W  screen base word address.
- line_offset  in  8  words added at end of each line (STe LINEWID).
- hscroll  in  4  STe pixel scroll value.
- ram_req  out  1  read request; held until ack.
- ram_addr  out  ADDR_W  read word address.
- ram_ack  in  1  one-cycle acknowledge; ram_din valid in the same cycle.
- ram_din  in  16  read data.
- LOAD  out  1  strobe to the shifter; its rising edge latches DOUT.
- DOUT  out  16  word to the shifter.
- scroll  out  1  to the shifter scroll input; high when hscroll != 0.
- vaddr  out  ADDR_W  current video address, for readback.
- overrun  out  1  sticky flag: a slot arrived while a fetch was still pending.

Behaviour:
- Reset values: ram_req=0, LOAD=0, DOUT=0, vaddr=0, overrun=0, FSM=IDLE, extra=0.
- Reset mid-fetch: ram_req drops on the next edge; any late ram_ack is ignored.
- FSM states:
  - IDLE -> REQ on slot_en when fetch_active.
  - REQ drives ram_req=1 with ram_addr=vaddr and stays there until ram_ack.
  - On ram_ack: DOUT<=ram_din, vaddr<=vaddr+1, go to PULSE.
  - PULSE holds LOAD=1 for exactly LOAD_LEN cycles, then returns to IDLE.
- Latency:
  - ram_req asserts 1 cycle after slot_en.
  - LOAD rises 1 cycle after the ram_ack cycle.
  - DOUT is stable from the ack edge until the next ack.
- fetch_active = DE | (extra != 0).
- Hard scroll:
  - On the DE falling edge with hscroll != 0: extra <= planes(rez), i.e. 4/2/1.
  - Each completed extra fetch decrements extra.
- End of line:
  - When DE is low, extra==0 and FSM==IDLE, and the line has not yet been closed: vaddr <= vaddr + line_offset (zero-extended), exactly once per line.
  - The line-closed flag clears on the DE rising edge.
- vsync rising edge has priority over everything:
  - vaddr <= vbase, extra <= 0, line closed.
  - An in-flight request completes normally (its data is delivered) but does not increment vaddr.
- Slot while busy:
  - slot_en in REQ or PULSE sets overrun and the slot is dropped.
  - overrun clears only on reset.
- Address arithmetic wraps modulo 2^ADDR_W.
- DE falling during REQ: the request still completes and LOAD is still issued.

Optional Feature:
- Macro STE_SCROLL_EN.
- Defined: line_offset and hscroll behave as above.
- Undefined: plain ST behaviour.
  - line_offset and hscroll are ignored.
  - scroll tied to 0, extra stays 0.
  - End-of-line add is 0.

Decomposition:
- Shared package gstmcu_video_pkg holds:
  - the FSM state enum (IDLE, REQ, PULSE);
  - rez encodings;
  - the planes(rez) function;
  - LOAD_LEN default.
- One natural sub-module: shifter_fetch_addr, the video address counter. It owns vbase reload, +1 increment, line-offset add and the vsync/end-of-line priority.

Test Plan:
- Basic fetch: reset, vbase=0x1000, DE high, slot_en every 16, ack 3 cycles after req -> addresses 0x1000, 0x1001, …; LOAD is 4 cycles wide; DOUT equals ram_din each slot.
- Line offset: 40 words per line, line_offset=8 -> second line starts at vbase+48; exactly one add per line.
- Hard scroll, low rez: hscroll=5 -> 4 extra fetches after DE falls; scroll=1; line add happens after the 4th extra word. With rez=2, exactly 1 extra fetch.
- Overrun: hold ram_ack off for 20 cycles -> the next slot_en sets overrun=1, the slot is dropped, and vaddr advances only once.
- vsync mid-request: vsync rises while in REQ -> vaddr=vbase after ack and is not incremented; the next fetch reads from vbase.
- Reset mid-fetch, plus macro-off build: reset asserted in REQ -> ram_req=0 and LOAD=0 next cycle. With STE_SCROLL_EN undefined and hscroll=5, line_offset=8 -> no extra fetches and no line add.
